upd_slowphy_to_llr_mc: RTL and testbench
========================================

Name: upd_slowphy_to_llr_mc

Overview:
- Parametrised successor of the slow-PHY-to-LLR unpacker.
- Per user allocation, fetches packed IQ words and packed noise words from two upstream FIFOs and emits RE_PER_BEAT REs per strobe to the LLR stage.
- Each beat carries the noise sample that covers the current group of i_user_iq_noise_rate REs.
- New over the previous generation: configurable lane/RE counts, downstream backpressure, start/last/done framing and configuration checking.

Parameters:
- DW, 16, sample width in bits.
- IQ_LANES, 8, DW-bit lanes per IQ FIFO word. Lane 2k is I and lane 2k+1 is Q of RE k. Lane 0 is bits [DW-1:0]. Must be even, and IQ_LANES/2 must be a multiple of RE_PER_BEAT.
- NOISE_LANES, 8, noise samples per noise FIFO word. Lane 0 is used first.
- RE_PER_BEAT, 2, REs output per strobe.
- CNT_W, 16, width of the RE count and rate fields.

Ports:
- i_core_clk  in  1  core clock.
- i_rx_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; latches the config and starts an allocation (honoured in IDLE only).
- i_user_iq_noise_rate  in  CNT_W  REs per noise sample.
- i_cur_user_re_amounts  in  CNT_W  total REs in this allocation.
- IQ_Data_SUM  in  IQ_LANES*DW  IQ FIFO read data; valid the cycle after the read enable.
- Noise_Data_SUM  in  NOISE_LANES*DW  noise FIFO read data; same 1-cycle read latency.
- IQ_FIFO_Empty  in  1.
- Noise_FIFO_Empty  in  1.
- i_llr_ready  in  1  downstream may accept a beat.
- IQ_FIFO_Read_Enable  out  1.
- Noise_FIFO_Read_Enable  out  1.
- o_data_strobe  out  1  one-cycle pulse per beat.
- o_re_data_i  out  RE_PER_BEAT*DW  I of beat RE k at [k*DW +: DW].
- o_re_data_q  out  RE_PER_BEAT*DW  Q, same mapping.
- o_noise_data  out  DW  noise sample for the beat.
- o_last  out  1  with the final strobe of the allocation.
- o_done  out  1  one-cycle pulse after the final beat.
- o_cfg_err  out  1  sticky configuration error.
- o_busy  out  1  high outside IDLE.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, holding registers invalid, counters 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, on i_start, checks the config. Error if rate==0, amounts==0, rate%RE_PER_BEAT!=0 or amounts%RE_PER_BEAT!=0.
  - On error: set o_cfg_err and stay in IDLE.
  - Otherwise: clear o_cfg_err, latch the config, clear counters, go to RUN.
- o_cfg_err is cleared only by the next valid i_start or by reset.
- i_start outside IDLE is ignored.
- Holding registers: one IQ word and one noise word, each with a valid flag and a lane pointer.
- Read rule: in RUN, a FIFO read enable is high in cycle C only if all of the following hold:
  - its holding register is invalid;
  - no read of that FIFO is in flight (issued in C-1);
  - the FIFO is not empty;
  - REs remain that need that word.
- Read capture: the data is captured at the end of C+1 and the register is valid from C+2.
- Reads are never issued when Empty=1; no underflow is possible.
- Beat rule: in RUN cycle B, a beat is taken if both registers are valid, i_llr_ready=1 and the remaining RE count is greater than 0.
  - o_data_strobe, data, o_noise_data and o_last are registered and appear in cycle B+1.
  - With i_llr_ready=0, no beat is taken and state is frozen; reads may still fill invalid registers.
  - Output data holds its last value between strobes.
- IQ consumption: each beat consumes RE_PER_BEAT REs (2*RE_PER_BEAT lanes). When the last lane of the word is consumed, the IQ register goes invalid.
- Noise consumption: the noise RE counter is incremented by RE_PER_BEAT per beat.
  - When it reaches the rate, it resets to 0 and the noise lane pointer advances.
  - Past lane NOISE_LANES-1, the noise register goes invalid.
- Last beat: when remaining REs equal RE_PER_BEAT, the beat carries o_last=1 and the FSM goes to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE. Residual lanes in the holding registers are discarded and the registers invalidated. No further reads are issued.
- Read counts: exactly ceil(amounts/(IQ_LANES/2)) IQ reads and ceil(amounts/(rate*NOISE_LANES)) noise reads per allocation.
- Reset asserted mid-allocation: immediate return to the reset state; any in-flight read data is ignored.
- A FIFO going empty mid-run only stalls beats; no data is lost or duplicated.

Test Plan:
- Defaults, rate=6, amounts=1800, both FIFOs non-empty, IQ and noise lanes 7..0 = 0x77,0x66,0x55,0x44,0x33,0x22,0x11,0x0C, i_llr_ready=1 -> required response:
  - exactly 900 strobes; 450 IQ reads and 38 noise reads;
  - beat0: i=0x0022000C, q=0x00330011;
  - beat1: i=0x00660044, q=0x00770055;
  - o_noise_data=0x000C on beats 0-2 and 0x0011 on beats 3-5;
  - o_last on strobe 900; o_done the following cycle.
- First-beat latency: i_start in cycle 0 -> read enables in cycle 1, first o_data_strobe in cycle 4.
- Noise_FIFO_Empty=1 for 39 cycles while the noise register is exhausted -> no Noise_FIFO_Read_Enable and no strobes during that window; the sequence resumes with the next noise word, no gaps or repeats in the data.
- i_llr_ready toggling 0/1 every 3 cycles -> strobes only derived from ready-high cycles; data order identical to the first scenario.
- i_start with rate=5 or amounts=1801 -> o_cfg_err=1, no FIFO reads, no strobe, o_done=0; a following valid i_start clears o_cfg_err.
- i_rx_rst pulsed after strobe 100 -> all outputs 0 immediately; a fresh i_start repeats the first scenario exactly.

Source files
------------

// File: rtl/upd_slowphy_to_llr_mc.sv
// Unpacks per-user IQ and noise FIFO words into RE_PER_BEAT-wide beats for the LLR stage,
// with downstream backpressure, start/last/done framing and a sticky configuration check.
module upd_slowphy_to_llr_mc #(
  parameter int DW          = 16,
  parameter int IQ_LANES    = 8,
  parameter int NOISE_LANES = 8,
  parameter int RE_PER_BEAT = 2,
  parameter int CNT_W       = 16
) (
  input  logic                        i_core_clk,
  input  logic                        i_rx_rst,
  input  logic                        i_start,
  input  logic [CNT_W-1:0]            i_user_iq_noise_rate,
  input  logic [CNT_W-1:0]            i_cur_user_re_amounts,
  input  logic [IQ_LANES*DW-1:0]      IQ_Data_SUM,
  input  logic [NOISE_LANES*DW-1:0]   Noise_Data_SUM,
  input  logic                        IQ_FIFO_Empty,
  input  logic                        Noise_FIFO_Empty,
  input  logic                        i_llr_ready,
  output logic                        IQ_FIFO_Read_Enable,
  output logic                        Noise_FIFO_Read_Enable,
  output logic                        o_data_strobe,
  output logic [RE_PER_BEAT*DW-1:0]   o_re_data_i,
  output logic [RE_PER_BEAT*DW-1:0]   o_re_data_q,
  output logic [DW-1:0]               o_noise_data,
  output logic                        o_last,
  output logic                        o_done,
  output logic                        o_cfg_err,
  output logic                        o_busy
);

  localparam int RE_PER_WORD = IQ_LANES / 2;
  localparam int IP_W = (RE_PER_WORD > 1) ? $clog2(RE_PER_WORD) : 1;
  localparam int NP_W = (NOISE_LANES > 1) ? $clog2(NOISE_LANES) : 1;
  localparam int FW   = CNT_W + NP_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          rate_q, rate_d;
  logic [CNT_W-1:0]          re_rem_q, re_rem_d;
  logic [CNT_W-1:0]          iq_fetch_q, iq_fetch_d;
  logic [FW-1:0]             nz_fetch_q, nz_fetch_d;
  logic                      iq_vld_q, iq_vld_d, nz_vld_q, nz_vld_d;
  logic [IQ_LANES*DW-1:0]    iq_word_q, iq_word_d;
  logic [NOISE_LANES*DW-1:0] nz_word_q, nz_word_d;
  logic [IP_W-1:0]           iq_ptr_q, iq_ptr_d;
  logic [NP_W-1:0]           nz_ptr_q, nz_ptr_d;
  logic [CNT_W-1:0]          nz_cnt_q, nz_cnt_d;
  logic                      iq_rd_q, iq_rd_d, nz_rd_q, nz_rd_d;
  logic                      strobe_q, strobe_d, last_q, last_d, done_q, done_d, err_q, err_d;
  logic [RE_PER_BEAT*DW-1:0] re_i_q, re_i_d, re_q_q, re_q_d;
  logic [DW-1:0]             noise_q, noise_d;
  logic                      cfg_bad;
  logic [FW-1:0]             nz_step;

  assign cfg_bad = (i_user_iq_noise_rate == '0) || (i_cur_user_re_amounts == '0) ||
                   ((i_user_iq_noise_rate % CNT_W'(RE_PER_BEAT)) != '0) ||
                   ((i_cur_user_re_amounts % CNT_W'(RE_PER_BEAT)) != '0);
  // REs covered by one noise word: rate REs per sample times lanes per word
  assign nz_step = FW'(rate_q) * FW'(NOISE_LANES);

  always_comb begin
    state_d    = state_q;
    rate_d     = rate_q;
    re_rem_d   = re_rem_q;
    iq_fetch_d = iq_fetch_q;
    nz_fetch_d = nz_fetch_q;
    iq_vld_d   = iq_vld_q;
    nz_vld_d   = nz_vld_q;
    iq_word_d  = iq_word_q;
    nz_word_d  = nz_word_q;
    iq_ptr_d   = iq_ptr_q;
    nz_ptr_d   = nz_ptr_q;
    nz_cnt_d   = nz_cnt_q;
    iq_rd_d    = 1'b0;
    nz_rd_d    = 1'b0;
    strobe_d   = 1'b0;
    last_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    re_i_d     = re_i_q;
    re_q_d     = re_q_q;
    noise_d    = noise_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            err_d      = 1'b0;
            rate_d     = i_user_iq_noise_rate;
            re_rem_d   = i_cur_user_re_amounts;
            iq_fetch_d = i_cur_user_re_amounts;
            nz_fetch_d = FW'(i_cur_user_re_amounts);
            iq_ptr_d   = '0;
            nz_ptr_d   = '0;
            nz_cnt_d   = '0;
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        iq_rd_d = !iq_vld_q && !iq_rd_q && !IQ_FIFO_Empty && (iq_fetch_q != '0);
        nz_rd_d = !nz_vld_q && !nz_rd_q && !Noise_FIFO_Empty && (nz_fetch_q != '0);
        if (iq_rd_d)
          iq_fetch_d = (iq_fetch_q > CNT_W'(RE_PER_WORD)) ? iq_fetch_q - CNT_W'(RE_PER_WORD) : '0;
        if (nz_rd_d)
          nz_fetch_d = (nz_fetch_q > nz_step) ? nz_fetch_q - nz_step : '0;
        if (iq_rd_q) begin
          iq_word_d = IQ_Data_SUM;
          iq_vld_d  = 1'b1;
        end
        if (nz_rd_q) begin
          nz_word_d = Noise_Data_SUM;
          nz_vld_d  = 1'b1;
        end
        if (iq_vld_q && nz_vld_q && i_llr_ready && (re_rem_q != '0)) begin
          strobe_d = 1'b1;
          for (int k = 0; k < RE_PER_BEAT; k++) begin
            re_i_d[k*DW +: DW] = iq_word_q[(2 * (int'(iq_ptr_q) + k)) * DW +: DW];
            re_q_d[k*DW +: DW] = iq_word_q[(2 * (int'(iq_ptr_q) + k) + 1) * DW +: DW];
          end
          noise_d  = nz_word_q[int'(nz_ptr_q) * DW +: DW];
          re_rem_d = re_rem_q - CNT_W'(RE_PER_BEAT);
          if (int'(iq_ptr_q) + RE_PER_BEAT >= RE_PER_WORD) begin
            iq_ptr_d = '0;
            iq_vld_d = 1'b0;
          end else begin
            iq_ptr_d = iq_ptr_q + IP_W'(RE_PER_BEAT);
          end
          if (nz_cnt_q + CNT_W'(RE_PER_BEAT) == rate_q) begin
            nz_cnt_d = '0;
            if (nz_ptr_q == NP_W'(NOISE_LANES - 1)) begin
              nz_ptr_d = '0;
              nz_vld_d = 1'b0;
            end else begin
              nz_ptr_d = nz_ptr_q + 1'b1;
            end
          end else begin
            nz_cnt_d = nz_cnt_q + CNT_W'(RE_PER_BEAT);
          end
          if (re_rem_q == CNT_W'(RE_PER_BEAT)) begin
            last_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d   = 1'b1;
        iq_vld_d = 1'b0;
        nz_vld_d = 1'b0;
        iq_ptr_d = '0;
        nz_ptr_d = '0;
        nz_cnt_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      state_q    <= S_IDLE;
      rate_q     <= '0;
      re_rem_q   <= '0;
      iq_fetch_q <= '0;
      nz_fetch_q <= '0;
      iq_vld_q   <= 1'b0;
      nz_vld_q   <= 1'b0;
      iq_word_q  <= '0;
      nz_word_q  <= '0;
      iq_ptr_q   <= '0;
      nz_ptr_q   <= '0;
      nz_cnt_q   <= '0;
      iq_rd_q    <= 1'b0;
      nz_rd_q    <= 1'b0;
      strobe_q   <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      re_i_q     <= '0;
      re_q_q     <= '0;
      noise_q    <= '0;
    end else begin
      state_q    <= state_d;
      rate_q     <= rate_d;
      re_rem_q   <= re_rem_d;
      iq_fetch_q <= iq_fetch_d;
      nz_fetch_q <= nz_fetch_d;
      iq_vld_q   <= iq_vld_d;
      nz_vld_q   <= nz_vld_d;
      iq_word_q  <= iq_word_d;
      nz_word_q  <= nz_word_d;
      iq_ptr_q   <= iq_ptr_d;
      nz_ptr_q   <= nz_ptr_d;
      nz_cnt_q   <= nz_cnt_d;
      iq_rd_q    <= iq_rd_d;
      nz_rd_q    <= nz_rd_d;
      strobe_q   <= strobe_d;
      last_q     <= last_d;
      done_q     <= done_d;
      err_q      <= err_d;
      re_i_q     <= re_i_d;
      re_q_q     <= re_q_d;
      noise_q    <= noise_d;
    end
  end

  assign IQ_FIFO_Read_Enable    = iq_rd_d;
  assign Noise_FIFO_Read_Enable = nz_rd_d;
  assign o_data_strobe          = strobe_q;
  assign o_re_data_i            = re_i_q;
  assign o_re_data_q            = re_q_q;
  assign o_noise_data           = noise_q;
  assign o_last                 = last_q;
  assign o_done                 = done_q;
  assign o_cfg_err              = err_q;
  assign o_busy                 = (state_q != S_IDLE);

endmodule

// File: tb/tb_upd_slowphy_to_llr_mc.sv
// Bench for upd_slowphy_to_llr_mc: FIFO models driven from the main process, beats compared
// against an RE-index reference model of the IQ/noise word streams.
module tb_upd_slowphy_to_llr_mc;
  localparam int DW = 16, IQL = 8, NL = 8, RPB = 2, CW = 16;
  localparam logic [IQL*DW-1:0] PAT = 128'h0077_0066_0055_0044_0033_0022_0011_000C;

  logic clk = 1'b0;
  logic rst, i_start, iq_empty, nz_empty, rdy;
  logic [CW-1:0] rate, amts;
  logic [IQL*DW-1:0] iq_data;
  logic [NL*DW-1:0] nz_data;
  logic iq_re, nz_re, strobe, last, done, cfg_err, busy;
  logic [RPB*DW-1:0] re_i, re_q;
  logic [DW-1:0] noise;

  always #5 clk = ~clk;

  upd_slowphy_to_llr_mc #(.DW(DW), .IQ_LANES(IQL), .NOISE_LANES(NL), .RE_PER_BEAT(RPB), .CNT_W(CW)) dut (
    .i_core_clk(clk), .i_rx_rst(rst), .i_start(i_start),
    .i_user_iq_noise_rate(rate), .i_cur_user_re_amounts(amts),
    .IQ_Data_SUM(iq_data), .Noise_Data_SUM(nz_data),
    .IQ_FIFO_Empty(iq_empty), .Noise_FIFO_Empty(nz_empty), .i_llr_ready(rdy),
    .IQ_FIFO_Read_Enable(iq_re), .Noise_FIFO_Read_Enable(nz_re),
    .o_data_strobe(strobe), .o_re_data_i(re_i), .o_re_data_q(re_q), .o_noise_data(noise),
    .o_last(last), .o_done(done), .o_cfg_err(cfg_err), .o_busy(busy));

  logic [IQL*DW-1:0] iq_mem [0:511];
  logic [NL*DW-1:0]  nz_mem [0:63];
  logic [RPB*DW-1:0] obs_i[$], obs_q[$], exp_i[$], exp_q[$];
  logic [DW-1:0]     obs_n[$], exp_n[$];
  int obs_cyc[$];
  int errors = 0, checks = 0, cyc = 0;
  int iq_idx, nz_idx, n_iq_rd, n_nz_rd, n_last, last_idx, n_done, done_cyc, first_rd_cyc, start_cyc;
  int bad_rdy, gap_strobes, gap_nrd, gap_seen, timed_out;
  logic prev_rdy, busy_at_done, err_seen;

  task automatic cycle();
    logic rd_iq, rd_nz;
    @(negedge clk);
    rd_iq = iq_re;
    rd_nz = nz_re;
    if (rd_iq) begin
      n_iq_rd++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (rd_nz) n_nz_rd++;
    if (strobe) begin
      obs_i.push_back(re_i); obs_q.push_back(re_q); obs_n.push_back(noise); obs_cyc.push_back(cyc);
      if (!prev_rdy) bad_rdy++;
      if (last) begin n_last++; last_idx = obs_i.size() - 1; end
    end
    if (done) begin n_done++; done_cyc = cyc; busy_at_done = busy; end
    err_seen = cfg_err;
    prev_rdy = rdy;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_iq) begin iq_data = iq_mem[iq_idx % 512]; iq_idx++; end
    if (rd_nz) begin nz_data = nz_mem[nz_idx % 64]; nz_idx++; end
  endtask

  task automatic clear_mon();
    obs_i.delete(); obs_q.delete(); obs_n.delete(); obs_cyc.delete();
    iq_idx = 0; nz_idx = 0; n_iq_rd = 0; n_nz_rd = 0; n_last = 0; last_idx = -1;
    n_done = 0; done_cyc = -1; first_rd_cyc = -1; bad_rdy = 0;
    gap_strobes = -1; gap_nrd = -1; gap_seen = 0; timed_out = 0; busy_at_done = 1'b1;
  endtask

  task automatic fill(input bit fixed);
    for (int w = 0; w < 512; w++)
      iq_mem[w] = fixed ? PAT : {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int w = 0; w < 64; w++)
      nz_mem[w] = fixed ? PAT : {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Reference: RE r lives in IQ word r/(IQL/2); its noise sample is index r/rate in the noise stream
  task automatic build_exp(input int r, input int a);
    logic [RPB*DW-1:0] ei, eq;
    logic [IQL*DW-1:0] w;
    logic [NL*DW-1:0]  nw;
    int re, l, s;
    exp_i.delete(); exp_q.delete(); exp_n.delete();
    for (int n = 0; n < a / RPB; n++) begin
      for (int k = 0; k < RPB; k++) begin
        re = n * RPB + k;
        w = iq_mem[re / (IQL / 2)];
        l = (re % (IQL / 2)) * 2;
        ei[k*DW +: DW] = w[l*DW +: DW];
        eq[k*DW +: DW] = w[(l + 1)*DW +: DW];
      end
      s = (n * RPB) / r;
      nw = nz_mem[s / NL];
      exp_i.push_back(ei); exp_q.push_back(eq); exp_n.push_back(nw[(s % NL)*DW +: DW]);
    end
  endtask

  // mode: 0 steady, 1 ready toggles every 3 cycles, 2 noise FIFO gap, 3 random stalls
  task automatic run_alloc(input int r, input int a, input int mode, input int abort_at, input int budget);
    int phase, gap_start, str0, nrd0;
    clear_mon();
    phase = 0; gap_start = 0; str0 = 0; nrd0 = 0;
    rate = CW'(r); amts = CW'(a);
    i_start = 1'b1; start_cyc = cyc;
    cycle();
    i_start = 1'b0;
    for (int t = 0; t < budget; t++) begin
      if (mode == 1) rdy = ((cyc / 3) % 2) == 0;
      if (mode == 3) begin
        rdy = $urandom_range(0, 3) != 0;
        iq_empty = $urandom_range(0, 3) == 0;
        nz_empty = $urandom_range(0, 3) == 0;
      end
      if (mode == 2) begin
        if (phase == 0 && n_nz_rd >= 1) begin nz_empty = 1'b1; phase = 1; end
        else if (phase == 1 && obs_i.size() >= 24) begin
          phase = 2; gap_start = cyc; str0 = obs_i.size(); nrd0 = n_nz_rd;
        end else if (phase == 2 && cyc - gap_start >= 39) begin
          gap_strobes = obs_i.size() - str0; gap_nrd = n_nz_rd - nrd0; gap_seen = 1;
          nz_empty = 1'b0; phase = 3;
        end
      end
      cycle();
      if (n_done > 0) break;
      if (abort_at > 0 && obs_i.size() >= abort_at) break;
      if (t == budget - 1) timed_out = 1;
    end
    rdy = 1'b1; iq_empty = 1'b0; nz_empty = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; rate = '0; amts = '0; iq_empty = 1'b0; nz_empty = 1'b0; rdy = 1'b1;
    iq_data = '0; nz_data = '0; prev_rdy = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    checks++;
    if ({strobe, last, done, cfg_err, busy, iq_re, nz_re} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 0000000", {strobe, last, done, cfg_err, busy, iq_re, nz_re});
    end
    checks++;
    if ({re_i, re_q, noise} !== '0) begin
      errors++; $display("FAIL reset_data: got i=%h q=%h n=%h required 0", re_i, re_q, noise);
    end
  endtask

  task automatic test_default();
    fill(1'b1);
    run_alloc(6, 1800, 0, 0, 5000);
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL default_timeout: got %0d required 0", timed_out); end
    checks++; if (obs_i.size() !== 900) begin errors++; $display("FAIL default_strobes: got %0d required 900", obs_i.size()); end
    checks++; if (n_iq_rd !== 450) begin errors++; $display("FAIL default_iq_reads: got %0d required 450", n_iq_rd); end
    checks++; if (n_nz_rd !== 38) begin errors++; $display("FAIL default_noise_reads: got %0d required 38", n_nz_rd); end
    checks++;
    if (obs_i.size() < 2 || obs_i[0] !== 32'h0022000C || obs_q[0] !== 32'h00330011) begin
      errors++; $display("FAIL beat0: got i=%h q=%h required i=0022000c q=00330011", obs_i[0], obs_q[0]);
    end
    checks++;
    if (obs_i.size() < 2 || obs_i[1] !== 32'h00660044 || obs_q[1] !== 32'h00770055) begin
      errors++; $display("FAIL beat1: got i=%h q=%h required i=00660044 q=00770055", obs_i[1], obs_q[1]);
    end
    for (int n = 0; n < 6 && n < obs_n.size(); n++) begin
      checks++;
      if (obs_n[n] !== ((n < 3) ? 16'h000C : 16'h0011)) begin
        errors++; $display("FAIL noise_beat%0d: got %h required %h", n, obs_n[n], (n < 3) ? 16'h000C : 16'h0011);
      end
    end
    checks++; if (n_last !== 1 || last_idx !== 899) begin errors++; $display("FAIL last_pos: got count=%0d idx=%0d required 1 at 899", n_last, last_idx); end
    checks++;
    if (n_done !== 1 || obs_cyc.size() == 0 || done_cyc !== obs_cyc[obs_cyc.size()-1] + 1) begin
      errors++; $display("FAIL done_timing: got count=%0d cycle=%0d required 1 cycle after last strobe", n_done, done_cyc);
    end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL busy_after: got %b required 0", busy_at_done); end
    checks++; if (first_rd_cyc !== start_cyc + 1) begin errors++; $display("FAIL read_latency: got %0d required %0d", first_rd_cyc - start_cyc, 1); end
    checks++;
    if (obs_cyc.size() == 0 || obs_cyc[0] !== start_cyc + 4) begin
      errors++; $display("FAIL strobe_latency: got %0d required 4", (obs_cyc.size() > 0) ? obs_cyc[0] - start_cyc : -1);
    end
  endtask

  task automatic test_random();
    int r, a;
    for (int it = 0; it < 3; it++) begin
      r = 2 * $urandom_range(1, 10);
      a = 2 * $urandom_range(1, 200);
      fill(1'b0);
      run_alloc(r, a, 3, 0, 6000);
      build_exp(r, a);
      checks++; if (timed_out !== 0) begin errors++; $display("FAIL random_timeout: got %0d required 0", timed_out); end
      checks++; if (obs_i.size() !== exp_i.size()) begin errors++; $display("FAIL random_beats: got %0d required %0d", obs_i.size(), exp_i.size()); end
      for (int n = 0; n < obs_i.size() && n < exp_i.size(); n++) begin
        checks++;
        if (obs_i[n] !== exp_i[n] || obs_q[n] !== exp_q[n] || obs_n[n] !== exp_n[n]) begin
          errors++; $display("FAIL random_data[%0d]: got %h/%h/%h required %h/%h/%h", n, obs_i[n], obs_q[n], obs_n[n], exp_i[n], exp_q[n], exp_n[n]);
        end
      end
      checks++;
      if (n_iq_rd !== (a + 3) / 4 || n_nz_rd !== (a + r * NL - 1) / (r * NL)) begin
        errors++; $display("FAIL random_reads: got iq=%0d nz=%0d required iq=%0d nz=%0d", n_iq_rd, n_nz_rd, (a + 3) / 4, (a + r * NL - 1) / (r * NL));
      end
      checks++; if (n_last !== 1 || last_idx !== a / RPB - 1) begin errors++; $display("FAIL random_last: got %0d at %0d required 1 at %0d", n_last, last_idx, a / RPB - 1); end
    end
  endtask

  task automatic test_noise_gap();
    fill(1'b0);
    run_alloc(6, 400, 2, 0, 4000);
    build_exp(6, 400);
    checks++; if (timed_out !== 0 || gap_seen !== 1) begin errors++; $display("FAIL gap_timeout: got timeout=%0d gap=%0d required 0 1", timed_out, gap_seen); end
    checks++; if (gap_strobes !== 0) begin errors++; $display("FAIL gap_strobes: got %0d required 0", gap_strobes); end
    checks++; if (gap_nrd !== 0) begin errors++; $display("FAIL gap_noise_reads: got %0d required 0", gap_nrd); end
    checks++; if (obs_i.size() !== exp_i.size()) begin errors++; $display("FAIL gap_beats: got %0d required %0d", obs_i.size(), exp_i.size()); end
    for (int n = 0; n < obs_i.size() && n < exp_i.size(); n++) begin
      checks++;
      if (obs_i[n] !== exp_i[n] || obs_q[n] !== exp_q[n] || obs_n[n] !== exp_n[n]) begin
        errors++; $display("FAIL gap_data[%0d]: got %h/%h/%h required %h/%h/%h", n, obs_i[n], obs_q[n], obs_n[n], exp_i[n], exp_q[n], exp_n[n]);
      end
    end
  endtask

  task automatic test_ready_toggle();
    fill(1'b0);
    run_alloc(6, 1800, 1, 0, 10000);
    build_exp(6, 1800);
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL toggle_timeout: got %0d required 0", timed_out); end
    checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL toggle_ready: got %0d strobes after ready-low required 0", bad_rdy); end
    checks++; if (obs_i.size() !== 900) begin errors++; $display("FAIL toggle_beats: got %0d required 900", obs_i.size()); end
    for (int n = 0; n < obs_i.size() && n < exp_i.size(); n++) begin
      checks++;
      if (obs_i[n] !== exp_i[n] || obs_q[n] !== exp_q[n] || obs_n[n] !== exp_n[n]) begin
        errors++; $display("FAIL toggle_data[%0d]: got %h/%h/%h required %h/%h/%h", n, obs_i[n], obs_q[n], obs_n[n], exp_i[n], exp_q[n], exp_n[n]);
      end
    end
  endtask

  task automatic test_cfg_err();
    int bad_r [2] = '{5, 6};
    int bad_a [2] = '{1800, 1801};
    for (int c = 0; c < 2; c++) begin
      clear_mon();
      rate = CW'(bad_r[c]); amts = CW'(bad_a[c]);
      i_start = 1'b1;
      cycle();
      i_start = 1'b0;
      repeat (20) cycle();
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_set%0d: got %b required 1", c, cfg_err); end
      checks++;
      if (n_iq_rd !== 0 || n_nz_rd !== 0 || obs_i.size() !== 0 || n_done !== 0 || busy !== 1'b0) begin
        errors++; $display("FAIL cfg_err_quiet%0d: got rd=%0d/%0d strobes=%0d done=%0d busy=%b required 0", c, n_iq_rd, n_nz_rd, obs_i.size(), n_done, busy);
      end
    end
    fill(1'b0);
    run_alloc(4, 40, 0, 0, 500);
    build_exp(4, 40);
    checks++; if (err_seen !== 1'b0 || timed_out !== 0) begin errors++; $display("FAIL cfg_err_clear: got err=%b timeout=%0d required 0 0", err_seen, timed_out); end
    checks++; if (obs_i.size() !== 20 || n_done !== 1) begin errors++; $display("FAIL cfg_valid_run: got beats=%0d done=%0d required 20 1", obs_i.size(), n_done); end
    for (int n = 0; n < obs_i.size() && n < exp_i.size(); n++) begin
      checks++;
      if (obs_i[n] !== exp_i[n] || obs_q[n] !== exp_q[n] || obs_n[n] !== exp_n[n]) begin
        errors++; $display("FAIL cfg_data[%0d]: got %h/%h/%h required %h/%h/%h", n, obs_i[n], obs_q[n], obs_n[n], exp_i[n], exp_q[n], exp_n[n]);
      end
    end
  endtask

  task automatic test_reset_mid();
    fill(1'b1);
    run_alloc(6, 1800, 0, 100, 5000);
    checks++; if (obs_i.size() !== 100) begin errors++; $display("FAIL midrst_reach: got %0d strobes required 100", obs_i.size()); end
    rst = 1'b1;
    #1;
    checks++;
    if ({strobe, last, done, cfg_err, busy, iq_re, nz_re} !== 7'b0 || {re_i, re_q, noise} !== '0) begin
      errors++; $display("FAIL midrst_outputs: got flags=%b i=%h q=%h n=%h required 0", {strobe, last, done, cfg_err, busy, iq_re, nz_re}, re_i, re_q, noise);
    end
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    run_alloc(6, 1800, 0, 0, 5000);
    build_exp(6, 1800);
    checks++;
    if (timed_out !== 0 || obs_i.size() !== 900 || n_iq_rd !== 450 || n_nz_rd !== 38 || n_last !== 1 || n_done !== 1) begin
      errors++; $display("FAIL midrst_rerun: got beats=%0d iq=%0d nz=%0d last=%0d done=%0d required 900 450 38 1 1", obs_i.size(), n_iq_rd, n_nz_rd, n_last, n_done);
    end
    checks++;
    if (obs_i.size() < 2 || obs_i[0] !== 32'h0022000C || obs_q[1] !== 32'h00770055 || obs_n[3] !== 16'h0011) begin
      errors++; $display("FAIL midrst_data: got i0=%h q1=%h n3=%h required 0022000c 00770055 0011", obs_i[0], obs_q[1], obs_n[3]);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_ready_toggle();
    test_noise_gap();
    test_random();
    test_cfg_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
